genius_controller: RTL and testbench

- Moore FSM that sequences the Genius (Simon) game datapath.
- It drives the datapath control strobes R1, R2, E1–E4 and the display select SEL.
- It consumes the datapath status flags end_FPGA, end_User, end_time, win and match, plus a synchronized start/confirm button.
- It sits beside the datapath in the top level and is the only source of those control signals.

---
 rtl/genius_pkg.sv | 21 ++
 rtl/genius_controller_edge_detect.sv | 30 +++
 rtl/genius_controller.sv | 130 +++++++++++++
 tb/tb_genius_controller.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/genius_pkg.sv
`default_nettype none
// ============================================================================
// Module      : genius_pkg
// Description : Shared state encoding for the Genius (Simon) game controller.
// Revision    : 1.0 - initial release
// ============================================================================
package genius_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_INIT       = 3'd0;
    localparam logic [STATE_W-1:0] S_SETUP      = 3'd1;
    localparam logic [STATE_W-1:0] S_PLAY_FPGA  = 3'd2;
    localparam logic [STATE_W-1:0] S_PLAY_USER  = 3'd3;
    localparam logic [STATE_W-1:0] S_CHECK      = 3'd4;
    localparam logic [STATE_W-1:0] S_NEXT_ROUND = 3'd5;
    localparam logic [STATE_W-1:0] S_CLEAR      = 3'd6;
    localparam logic [STATE_W-1:0] S_RESULT     = 3'd7;

endpackage
`default_nettype wire

// File: rtl/genius_controller_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : edge_detect
// Description : Registered rising-edge detector with a configurable reset
//               value for the history flop.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    output logic o_rise
);

    logic r_din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_din_q <= RESET_VAL;
        end else begin
            r_din_q <= i_din;
        end
    end

    assign o_rise = i_din & ~r_din_q;

endmodule
`default_nettype wire

// File: rtl/genius_controller.sv
`default_nettype none
// ============================================================================
// Module      : genius_controller
// Description : Moore FSM sequencing the Genius game datapath strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module genius_controller
    import genius_pkg::*;
#(
    parameter int RESULT_HOLD = 4,
    parameter int HOLD_W      = 25
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               enter,
    input  logic               end_FPGA,
    input  logic               end_User,
    input  logic               end_time,
    input  logic               win,
    input  logic               match,
    output logic               R1,
    output logic               R2,
    output logic               E1,
    output logic               E2,
    output logic               E3,
    output logic               E4,
    output logic               SEL,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [HOLD_W-1:0] c_hold_max = HOLD_W'(RESULT_HOLD);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic               w_enter_rise;
    logic               w_hold_done;

    // History flop resets high so a button held through reset is not a press.
    edge_detect #(
        .RESET_VAL (1'b1)
    ) u_enter_edge (
        .clk    (CLOCK_50),
        .rst_n  (reset),
        .i_din  (enter),
        .o_rise (w_enter_rise)
    );

    assign w_hold_done = (r_hold_cnt == c_hold_max);

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_hold_cnt <= '0;
        end else if (r_state != S_RESULT) begin
            r_hold_cnt <= '0;
        end else if (w_enter_rise && w_hold_done) begin
            r_hold_cnt <= '0;
        end else if (!w_hold_done) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        R1  = 1'b0;
        R2  = 1'b0;
        E1  = 1'b0;
        E2  = 1'b0;
        E3  = 1'b0;
        E4  = 1'b0;
        SEL = 1'b0;
        case (r_state)
            S_INIT: begin
                R1  = 1'b1;
                R2  = 1'b1;
                SEL = 1'b1;
                w_next_state = S_SETUP;
            end
            S_SETUP: begin
                E1 = 1'b1;
                if (w_enter_rise) w_next_state = S_PLAY_FPGA;
            end
            S_PLAY_FPGA: begin
                E3  = 1'b1;
                SEL = 1'b1;
                if (end_FPGA) w_next_state = S_PLAY_USER;
            end
            S_PLAY_USER: begin
                E2  = 1'b1;
                SEL = 1'b1;
                // A finished entry wins over a simultaneous timeout.
                if (end_User)      w_next_state = S_CHECK;
                else if (end_time) w_next_state = S_RESULT;
            end
            S_CHECK: begin
                SEL = 1'b1;
                if (match && !win) w_next_state = S_NEXT_ROUND;
                else               w_next_state = S_RESULT;
            end
            S_NEXT_ROUND: begin
                E4  = 1'b1;
                SEL = 1'b1;
                w_next_state = S_CLEAR;
            end
            S_CLEAR: begin
                R2  = 1'b1;
                SEL = 1'b1;
                w_next_state = S_PLAY_FPGA;
            end
            S_RESULT: begin
                if (w_enter_rise && w_hold_done) w_next_state = S_INIT;
            end
            default: begin
                w_next_state = S_INIT;
            end
        endcase
    end

    assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_genius_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_genius_controller
// Description : Directed self-checking bench for genius_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_genius_controller;

    // Observed vector layout: {state_o[2:0], R1, R2, E1, E2, E3, E4, SEL}
    localparam logic [9:0] c_exp_s0 = 10'b000_1_1_0000_1;
    localparam logic [9:0] c_exp_s1 = 10'b001_0_0_1000_0;
    localparam logic [9:0] c_exp_s2 = 10'b010_0_0_0010_1;
    localparam logic [9:0] c_exp_s3 = 10'b011_0_0_0100_1;
    localparam logic [9:0] c_exp_s4 = 10'b100_0_0_0000_1;
    localparam logic [9:0] c_exp_s5 = 10'b101_0_0_0001_1;
    localparam logic [9:0] c_exp_s6 = 10'b110_0_1_0000_1;
    localparam logic [9:0] c_exp_s7 = 10'b111_0_0_0000_0;

    logic       clk;
    logic       reset;
    logic       enter;
    logic       end_FPGA;
    logic       end_User;
    logic       end_time;
    logic       win;
    logic       match;
    logic       R1, R2, E1, E2, E3, E4, SEL;
    logic [2:0] state_o;
    logic [9:0] w_obs;

    int n_tests = 0;
    int n_fail  = 0;

    genius_controller #(
        .RESULT_HOLD (4),
        .HOLD_W      (25)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .enter    (enter),
        .end_FPGA (end_FPGA),
        .end_User (end_User),
        .end_time (end_time),
        .win      (win),
        .match    (match),
        .R1       (R1),
        .R2       (R2),
        .E1       (E1),
        .E2       (E2),
        .E3       (E3),
        .E4       (E4),
        .SEL      (SEL),
        .state_o  (state_o)
    );

    assign w_obs = {state_o, R1, R2, E1, E2, E3, E4, SEL};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs and samples change 1 time unit after the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_enter();
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; enter = 1'b1;
        end_FPGA = 1'b0; end_User = 1'b0; end_time = 1'b0;
        win = 1'b0; match = 1'b0;
        tick(2);
        n_tests++;
        if (w_obs !== c_exp_s0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", w_obs, c_exp_s0);
        end
        reset = 1'b1;
        tick();
        n_tests++;
        if (w_obs !== c_exp_s1) begin
            n_fail++;
            $display("FAIL init_to_setup: got %b expected %b", w_obs, c_exp_s1);
        end
        tick(3);
        n_tests++;
        if (w_obs !== c_exp_s1) begin
            n_fail++;
            $display("FAIL held_enter_no_rise: got %b expected %b", w_obs, c_exp_s1);
        end
        enter = 1'b0;
        tick();
    endtask

    task automatic test_round();
        press_enter();
        n_tests++;
        if (w_obs !== c_exp_s2) begin
            n_fail++;
            $display("FAIL setup_to_fpga: got %b expected %b", w_obs, c_exp_s2);
        end
        end_time = 1'b1;
        tick();
        end_time = 1'b0;
        n_tests++;
        if (w_obs !== c_exp_s2) begin
            n_fail++;
            $display("FAIL end_time_ignored_in_fpga: got %b expected %b", w_obs, c_exp_s2);
        end
        end_FPGA = 1'b1;
        tick();
        end_FPGA = 1'b0;
        n_tests++;
        if (w_obs !== c_exp_s3) begin
            n_fail++;
            $display("FAIL fpga_to_user: got %b expected %b", w_obs, c_exp_s3);
        end
        end_User = 1'b1; match = 1'b1; win = 1'b0;
        tick();
        end_User = 1'b0;
        n_tests++;
        if (w_obs !== c_exp_s4) begin
            n_fail++;
            $display("FAIL user_to_check: got %b expected %b", w_obs, c_exp_s4);
        end
        tick();
        match = 1'b0;
        n_tests++;
        if (w_obs !== c_exp_s5) begin
            n_fail++;
            $display("FAIL check_to_next_round: got %b expected %b", w_obs, c_exp_s5);
        end
        tick();
        n_tests++;
        if (w_obs !== c_exp_s6) begin
            n_fail++;
            $display("FAIL next_round_to_clear: got %b expected %b", w_obs, c_exp_s6);
        end
        tick();
        n_tests++;
        if (w_obs !== c_exp_s2) begin
            n_fail++;
            $display("FAIL clear_to_fpga: got %b expected %b", w_obs, c_exp_s2);
        end
    endtask

    task automatic test_victory();
        end_FPGA = 1'b1;
        tick();
        end_FPGA = 1'b0;
        end_User = 1'b1; match = 1'b1; win = 1'b1;
        tick();
        end_User = 1'b0;
        tick();
        match = 1'b0; win = 1'b0;
        n_tests++;
        if (w_obs !== c_exp_s7) begin
            n_fail++;
            $display("FAIL victory_result: got %b expected %b", w_obs, c_exp_s7);
        end
        tick(2);
        press_enter();
        n_tests++;
        if (w_obs !== c_exp_s7) begin
            n_fail++;
            $display("FAIL early_enter_ignored: got %b expected %b", w_obs, c_exp_s7);
        end
        tick();
        press_enter();
        n_tests++;
        if (w_obs !== c_exp_s0) begin
            n_fail++;
            $display("FAIL result_to_init: got %b expected %b", w_obs, c_exp_s0);
        end
        tick();
        n_tests++;
        if (w_obs !== c_exp_s1) begin
            n_fail++;
            $display("FAIL init_to_setup_again: got %b expected %b", w_obs, c_exp_s1);
        end
    endtask

    task automatic go_home();
        tick(5);
        press_enter();
        tick();
    endtask

    task automatic to_play_user();
        press_enter();
        end_FPGA = 1'b1;
        tick();
        end_FPGA = 1'b0;
    endtask

    task automatic test_mismatch();
        to_play_user();
        end_User = 1'b1; match = 1'b0;
        tick();
        end_User = 1'b0;
        n_tests++;
        if (w_obs !== c_exp_s4) begin
            n_fail++;
            $display("FAIL mismatch_check: got %b expected %b", w_obs, c_exp_s4);
        end
        tick();
        n_tests++;
        if (w_obs !== c_exp_s7) begin
            n_fail++;
            $display("FAIL mismatch_loss: got %b expected %b", w_obs, c_exp_s7);
        end
        go_home();
        n_tests++;
        if (w_obs !== c_exp_s1) begin
            n_fail++;
            $display("FAIL mismatch_back_to_setup: got %b expected %b", w_obs, c_exp_s1);
        end
    endtask

    task automatic test_timeout_and_tie();
        to_play_user();
        end_time = 1'b1;
        tick();
        end_time = 1'b0;
        n_tests++;
        if (w_obs !== c_exp_s7) begin
            n_fail++;
            $display("FAIL timeout_loss: got %b expected %b", w_obs, c_exp_s7);
        end
        go_home();
        to_play_user();
        end_time = 1'b1; end_User = 1'b1; match = 1'b1; win = 1'b0;
        tick();
        end_time = 1'b0; end_User = 1'b0;
        n_tests++;
        if (w_obs !== c_exp_s4) begin
            n_fail++;
            $display("FAIL tie_end_user_priority: got %b expected %b", w_obs, c_exp_s4);
        end
        tick();
        match = 1'b0;
        n_tests++;
        if (w_obs !== c_exp_s5) begin
            n_fail++;
            $display("FAIL tie_next_round: got %b expected %b", w_obs, c_exp_s5);
        end
        tick(2);
    endtask

    task automatic test_async_reset();
        end_FPGA = 1'b1;
        tick();
        end_FPGA = 1'b0;
        n_tests++;
        if (w_obs !== c_exp_s3) begin
            n_fail++;
            $display("FAIL pre_reset_play_user: got %b expected %b", w_obs, c_exp_s3);
        end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if (w_obs !== c_exp_s0) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got %b expected %b", w_obs, c_exp_s0);
        end
        tick();
        #2 reset = 1'b1;
        tick();
        n_tests++;
        if (w_obs !== c_exp_s1) begin
            n_fail++;
            $display("FAIL post_reset_setup: got %b expected %b", w_obs, c_exp_s1);
        end
    endtask

    initial begin
        test_reset();
        test_round();
        test_victory();
        test_mismatch();
        test_timeout_and_tie();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
